// File: rtl/i2s_stereo_serializer_if.sv
// ----------------------------------------------------------------------------
// i2s_stereo_serializer_if
// Sample-pair handshake between the mixer (master) and the I2S serializer
// (slave).
//   s_valid  master -> slave  a stereo pair is presented
//   s_ready  slave -> master  the serializer holding buffer is empty
//   s_left   master -> slave  signed 16-bit left sample
//   s_right  master -> slave  signed 16-bit right sample
// ----------------------------------------------------------------------------
interface i2s_stereo_serializer_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_left;
   logic [15:0] s_right;

   // Upstream stage drives the pair and watches ready
   modport master (output s_valid, output s_left, output s_right, input s_ready);

   // Serializer consumes the pair and reports buffer space
   modport slave (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_stereo_serializer.sv
// ----------------------------------------------------------------------------
// i2s_stereo_serializer
// Takes one stereo pair per frame through a one-entry holding buffer and
// shifts it out MSB-first in Philips I2S format (data one BCLK behind each
// LRCLK edge). BCLK and LRCLK are derived from clk by integer division. When
// the buffer is empty at a frame boundary a silent frame is sent and underrun
// pulses.
// Ports:
//   clk          system clock, everything on its rising edge
//   aresetn      asynchronous active-low reset
//   s            sample-pair handshake (slave side)
//   frame_start  one-cycle pulse when a frame enters the shifter
//   underrun     one-cycle pulse when that frame is silence (buffer was empty)
//   audio_bclk   I2S bit clock
//   audio_lrclk  I2S word select, 0 = left, 1 = right
//   audio_dout   I2S serial data
// ----------------------------------------------------------------------------
module i2s_stereo_serializer #(
   parameter int CLK_DIV    = 12,
   parameter int SLOT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    aresetn,
   i2s_stereo_serializer_if.slave  s,
   output logic                    frame_start,
   output logic                    underrun,
   output logic                    audio_bclk,
   output logic                    audio_lrclk,
   output logic                    audio_dout
);

   localparam int FW = 2 * SLOT_WIDTH;
   localparam int DW = $clog2(CLK_DIV);
   localparam int PW = $clog2(FW);

   logic [DW-1:0] divCnt_q, divCnt_d;
   logic          bclk_q, bclk_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          lrclk_q, lrclk_d;
   logic          dout_q, dout_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [15:0]   bufLeft_q, bufLeft_d;
   logic [15:0]   bufRight_q, bufRight_d;
   logic          sReady_q, sReady_d;
   logic          frameStart_q, frameStart_d;
   logic          underrun_q, underrun_d;

   logic          divWrap;
   logic          fallEvent;
   logic          loadEvent;
   logic [PW-1:0] posNext;
   logic [PW-1:0] bitIdx;
   logic [FW-1:0] newFrame;

   // Timing decode: the divider wrap toggles BCLK, and only a wrap while BCLK
   // is high (a falling BCLK) may move data, word select or the slot position.
   // Entering position p shows frame bit FW-p, so bit FW-1 (the left MSB)
   // lands one BCLK after LRCLK falls. Entering position 0 shows bit 0, the
   // last right-slot bit of the frame that is leaving.
   always_comb begin
      divWrap   = (divCnt_q == DW'(CLK_DIV - 1));
      fallEvent = divWrap && bclk_q;
      posNext   = (pos_q == PW'(FW - 1)) ? '0 : pos_q + PW'(1);
      loadEvent = fallEvent && (posNext == '0);
      bitIdx    = (posNext == '0) ? '0 : PW'(FW - int'(posNext));
   end

   // Buffered pair laid out as the shifter expects: each sample sits at the
   // top of its slot and any extra slot bits below it are zero padding.
   always_comb begin
      newFrame                       = '0;
      newFrame[FW-1 -: 16]           = bufLeft_q;
      newFrame[SLOT_WIDTH-1 -: 16]   = bufRight_q;
   end

   // Next-state logic. The frame load is evaluated against the buffer state
   // held before this edge; a handshake transfer in the same cycle is applied
   // afterwards, so an empty buffer still underruns this frame and keeps the
   // new pair for the next one.
   always_comb begin
      divCnt_d     = divWrap ? '0 : divCnt_q + DW'(1);
      bclk_d       = divWrap ? ~bclk_q : bclk_q;
      pos_d        = pos_q;
      lrclk_d      = lrclk_q;
      dout_d       = dout_q;
      frame_d      = frame_q;
      bufLeft_d    = bufLeft_q;
      bufRight_d   = bufRight_q;
      sReady_d     = sReady_q;
      frameStart_d = 1'b0;
      underrun_d   = 1'b0;

      if (fallEvent) begin
         pos_d   = posNext;
         lrclk_d = (posNext >= PW'(SLOT_WIDTH));
         dout_d  = frame_q[bitIdx];
      end

      if (loadEvent) begin
         frame_d      = sReady_q ? '0 : newFrame;
         frameStart_d = 1'b1;
         underrun_d   = sReady_q;
         sReady_d     = 1'b1;
      end

      if (s.s_valid && sReady_q) begin
         bufLeft_d  = s.s_left;
         bufRight_d = s.s_right;
         sReady_d   = 1'b0;
      end
   end

   // State registers; reset drops any buffered pair and restarts the frame
   // at position 0 with an all-zero shifter.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         divCnt_q     <= '0;
         bclk_q       <= 1'b0;
         pos_q        <= '0;
         lrclk_q      <= 1'b0;
         dout_q       <= 1'b0;
         frame_q      <= '0;
         bufLeft_q    <= '0;
         bufRight_q   <= '0;
         sReady_q     <= 1'b1;
         frameStart_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         divCnt_q     <= divCnt_d;
         bclk_q       <= bclk_d;
         pos_q        <= pos_d;
         lrclk_q      <= lrclk_d;
         dout_q       <= dout_d;
         frame_q      <= frame_d;
         bufLeft_q    <= bufLeft_d;
         bufRight_q   <= bufRight_d;
         sReady_q     <= sReady_d;
         frameStart_q <= frameStart_d;
         underrun_q   <= underrun_d;
      end
   end

   assign s.s_ready   = sReady_q;
   assign frame_start = frameStart_q;
   assign underrun    = underrun_q;
   assign audio_bclk  = bclk_q;
   assign audio_lrclk = lrclk_q;
   assign audio_dout  = dout_q;

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// ----------------------------------------------------------------------------
// tb_i2s_stereo_serializer
// Two serializers (16- and 24-bit slots, CLK_DIV=2) are exercised one after
// the other. Stimulus pushes the expected content of every frame into a queue;
// an independent monitor pops an entry at each frame_start, captures the
// frame's bits on BCLK rising edges and compares them.
// ----------------------------------------------------------------------------
module tb_i2s_stereo_serializer;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic        und;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst16N, rst24N;
   logic        sel;
   logic        tValid;
   logic [15:0] tLeft, tRight;

   logic fs16, ur16, bclk16, lr16, dout16;
   logic fs24, ur24, bclk24, lr24, dout24;

   int   total   = 0;
   int   bad     = 0;
   int   doneCnt = 0;
   exp_t expQ[$];

   i2s_stereo_serializer_if if16 ();
   i2s_stereo_serializer_if if24 ();

   assign if16.s_valid = tValid;
   assign if16.s_left  = tLeft;
   assign if16.s_right = tRight;
   assign if24.s_valid = tValid;
   assign if24.s_left  = tLeft;
   assign if24.s_right = tRight;

   i2s_stereo_serializer #(.CLK_DIV(2), .SLOT_WIDTH(16)) dut16 (
      .clk(clk), .aresetn(rst16N), .s(if16.slave),
      .frame_start(fs16), .underrun(ur16), .audio_bclk(bclk16),
      .audio_lrclk(lr16), .audio_dout(dout16));

   i2s_stereo_serializer #(.CLK_DIV(2), .SLOT_WIDTH(24)) dut24 (
      .clk(clk), .aresetn(rst24N), .s(if24.slave),
      .frame_start(fs24), .underrun(ur24), .audio_bclk(bclk24),
      .audio_lrclk(lr24), .audio_dout(dout24));

   // The monitor and helper tasks look at whichever DUT is under test
   wire mFs    = sel ? fs24   : fs16;
   wire mUr    = sel ? ur24   : ur16;
   wire mBclk  = sel ? bclk24 : bclk16;
   wire mLr    = sel ? lr24   : lr16;
   wire mDout  = sel ? dout24 : dout16;
   wire mReady = sel ? if24.s_ready : if16.s_ready;
   wire mRstN  = sel ? rst24N : rst16N;

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic pushExp(input logic [15:0] l, input logic [15:0] r, input logic und);
      exp_t e;
      e.l = l;
      e.r = r;
      e.und = und;
      expQ.push_back(e);
   endtask

   // Called on a negedge; returns on the negedge after the transfer edge
   task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input bit expectAtLoad);
      int n = 0;
      tLeft  = l;
      tRight = r;
      tValid = 1'b1;
      while (!mReady && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ready seen", 64'(mReady), 64'(1));
      if (expectAtLoad) checkOutput("accept after load", 64'(mFs), 64'(1));
      @(negedge clk);
      tValid = 1'b0;
   endtask

   task automatic waitLoad();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mFs && n < 1000);
      checkOutput("load seen", 64'(mFs), 64'(1));
   endtask

   task automatic waitDone(input int target);
      int n = 0;
      while (doneCnt < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frames done", 64'(doneCnt), 64'(target));
   endtask

   task automatic measureBclk();
      int n = 0;
      int cnt = 0;
      while (!mBclk && n < 100) begin
         @(negedge clk);
         n++;
      end
      do begin
         @(negedge clk);
         cnt++;
      end while (mBclk && cnt < 100);
      do begin
         @(negedge clk);
         cnt++;
      end while (!mBclk && cnt < 100);
      checkOutput("bclk period", 64'(cnt), 64'(4));
   endtask

   // Starts just after a load (lrclk low); ends at the following load
   task automatic measureLrclk();
      int lo = 0;
      int hi = 0;
      do begin
         @(negedge clk);
         lo++;
      end while (!mLr && lo < 1000);
      do begin
         @(negedge clk);
         hi++;
      end while (mLr && hi < 1000);
      checkOutput("lrclk period", 64'(lo + hi), 64'(128));
      checkOutput("lrclk high time", 64'(hi), 64'(64));
      checkOutput("lrclk falls at load", 64'(mFs), 64'(1));
   endtask

   // Scoreboard monitor: at each frame_start pop the expected frame, then
   // capture FW bits on BCLK rises. The first captured bit is the previous
   // frame's last bit; the rest are the new frame's bits FW-1 down to 1.
   initial begin : monitor
      exp_t        cur;
      logic [47:0] cap, ef, mask;
      int          nBits, lrBad, fw, sw;
      bit          busy;
      logic        bPrev, prevLast;
      busy = 0; bPrev = 0; prevLast = 0; nBits = 0; lrBad = 0; cap = '0;
      cur.l = '0; cur.r = '0; cur.und = 1'b0;
      forever begin
         @(negedge clk);
         fw = sel ? 48 : 32;
         sw = fw / 2;
         if (!mRstN) begin
            busy = 0; bPrev = 0; prevLast = 0;
         end else begin
            if (mFs) begin
               checkOutput("frame expected", 64'(expQ.size() > 0), 64'(1));
               busy = 0;
               if (expQ.size() > 0) begin
                  cur = expQ.pop_front();
                  checkOutput("underrun flag", 64'(mUr), 64'(cur.und));
                  busy = 1; nBits = 0; lrBad = 0; cap = '0;
               end
            end else if (busy && mBclk && !bPrev) begin
               cap = {cap[46:0], mDout};
               if (mLr !== (nBits >= sw)) lrBad++;
               nBits++;
               if (nBits == fw) begin
                  ef   = (fw == 32) ? {16'h0, cur.l, cur.r} : {cur.l, 8'h00, cur.r, 8'h00};
                  mask = (48'h1 << (fw - 1)) - 48'h1;
                  checkOutput("carry bit", 64'(cap[fw-1]), 64'(prevLast));
                  checkOutput("frame bits", 64'(cap & mask), 64'((ef >> 1) & mask));
                  checkOutput("lrclk slots", 64'(lrBad), 64'(0));
                  prevLast = ef[0];
                  busy = 0;
                  doneCnt++;
               end
            end
            bPrev = mBclk;
         end
      end
   end

   initial begin : stimulus
      sel = 1'b0; rst16N = 1'b0; rst24N = 1'b0;
      tValid = 1'b0; tLeft = '0; tRight = '0;
      repeat (3) @(negedge clk);

      // Reset state and clock rates
      checkOutput("reset outputs", 64'({mBclk, mLr, mDout, mUr, mFs}), 64'(0));
      checkOutput("reset ready", 64'(mReady), 64'(1));
      rst16N = 1'b1;
      measureBclk();

      // First pair before the first wrap
      pushExp(16'hA5F0, 16'h0F0F, 1'b0);
      applyStimulus(16'hA5F0, 16'h0F0F, 1'b0);
      waitLoad();

      // Three idle frames
      pushExp(16'h0, 16'h0, 1'b1);
      pushExp(16'h0, 16'h0, 1'b1);
      pushExp(16'h0, 16'h0, 1'b1);
      measureLrclk();
      waitLoad();
      waitLoad();

      // Back-to-back pairs
      pushExp(16'h1234, 16'hFEDC, 1'b0);
      pushExp(16'h7FFF, 16'h8000, 1'b0);
      applyStimulus(16'h1234, 16'hFEDC, 1'b0);
      checkOutput("ready low while full", 64'(mReady), 64'(0));
      applyStimulus(16'h7FFF, 16'h8000, 1'b1);

      // Push that lands exactly on the load edge with an empty buffer
      pushExp(16'h0, 16'h0, 1'b1);
      pushExp(16'hC3A5, 16'h5A3C, 1'b0);
      waitLoad();
      repeat (127) @(negedge clk);
      tLeft = 16'hC3A5; tRight = 16'h5A3C; tValid = 1'b1;
      @(negedge clk);
      checkOutput("coincident load", 64'(mFs), 64'(1));
      checkOutput("coincident underrun", 64'(mUr), 64'(1));
      checkOutput("coincident accept", 64'(mReady), 64'(0));
      tValid = 1'b0;
      pushExp(16'h0, 16'h0, 1'b1);
      waitLoad();
      waitLoad();
      waitDone(9);

      // 24-bit slots
      sel = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset outputs 24", 64'({mBclk, mLr, mDout, mUr, mFs}), 64'(0));
      checkOutput("reset ready 24", 64'(mReady), 64'(1));
      rst24N = 1'b1;
      pushExp(16'h8001, 16'h7FFE, 1'b0);
      applyStimulus(16'h8001, 16'h7FFE, 1'b0);
      waitLoad();
      pushExp(16'hFFFF, 16'hC3C3, 1'b0);
      applyStimulus(16'hFFFF, 16'hC3C3, 1'b0);
      applyStimulus(16'h1234, 16'h5678, 1'b1);
      waitDone(10);

      // Asynchronous reset in the middle of the right slot
      repeat (140) @(negedge clk);
      checkOutput("right slot before reset", 64'(mLr), 64'(1));
      #2;
      rst24N = 1'b0;
      #1;
      checkOutput("async reset outputs", 64'({mBclk, mLr, mDout, mUr, mFs}), 64'(0));
      checkOutput("async reset ready", 64'(mReady), 64'(1));
      repeat (3) @(negedge clk);
      rst24N = 1'b1;
      pushExp(16'h0, 16'h0, 1'b1);
      waitLoad();
      waitDone(11);
      checkOutput("queue drained", 64'(expQ.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
